// File: rtl/fetch_if.sv
// Fetch-stage bundle: control from decode/execute, instruction-memory port, decoder-facing outputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_if;
  logic        run;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_valid;
  logic [31:0] fetch_count;

  modport master (
    input  run, stall, redirect_en, redirect_pc, imem_rdata,
    output imem_addr, imem_re, insn, pc, insn_valid, fetch_count
  );

  modport slave (
    output run, stall, redirect_en, redirect_pc, imem_rdata,
    input  imem_addr, imem_re, insn, pc, insn_valid, fetch_count
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, holds the output under stall,
// and inserts one NOP bubble after a redirect.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] rsp_pc;
  logic        rsp_vld;
  logic        hold_vld;
  logic [31:0] hold_insn;
  logic [31:0] count;
  logic        consume;
  logic        issue;
  logic [31:0] target;

  assign consume = rsp_vld & ~bus.stall;
  assign target  = {bus.redirect_pc[31:2], 2'b00};
  // A new read is launched whenever the output slot is empty or being drained this edge.
  assign issue   = (state == FLUSH) || ((state == FETCH) && (!rsp_vld || !bus.stall));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      rsp_pc    <= RESET_PC;
      rsp_vld   <= 1'b0;
      hold_vld  <= 1'b0;
      hold_insn <= NOP_INSN;
      count     <= 32'd0;
    end else begin
      if (consume)
        count <= count + 32'd1;

      if (bus.redirect_en) begin
        fpc      <= target;
        rsp_vld  <= 1'b0;
        hold_vld <= 1'b0;
        state    <= bus.run ? FLUSH : IDLE;
      end else if (!bus.run) begin
        state    <= IDLE;
        rsp_vld  <= 1'b0;
        hold_vld <= 1'b0;
        // Rewind to the unconsumed instruction so resume re-fetches it.
        if (rsp_vld && bus.stall)
          fpc <= rsp_pc;
      end else begin
        case (state)
          IDLE: state <= FETCH;
          FETCH, FLUSH: begin
            if (issue) begin
              rsp_vld  <= 1'b1;
              rsp_pc   <= fpc;
              fpc      <= fpc + 32'd4;
              hold_vld <= 1'b0;
              state    <= FETCH;
            end else begin
              hold_vld <= 1'b1;
              if (!hold_vld)
                hold_insn <= bus.imem_rdata;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.imem_addr   = fpc;
  assign bus.imem_re     = (state == FETCH) || (state == FLUSH);
  // The memory output register is the insn register until a stall parks the word in the hold register.
  assign bus.insn        = hold_vld ? hold_insn : (rsp_vld ? bus.imem_rdata : NOP_INSN);
  assign bus.pc          = rsp_pc;
  assign bus.insn_valid  = rsp_vld;
  assign bus.fetch_count = count;
endmodule
